int32_to_dlfloat16: RTL and testbench

- Pipelined converter from signed 32-bit integer to DLfloat16: 1 sign bit, 6 exponent bits with bias 31, 9 mantissa bits with a hidden 1.
- Inverse of the FPU's dlfloat16-to-int32 path. Selected by the same 4-bit `ena` opcode bus and reports through the same 5-bit exception vector.
- Three register stages with valid/ready handshakes on both sides. Full throughput of one conversion per cycle; backpressure is honoured.

---
 rtl/dlfloat16_pkg.sv | 16 +
 rtl/int32_to_dlfloat16_if.sv | 16 +
 rtl/lzc32.sv | 13 +
 rtl/int32_to_dlfloat16.sv | 102 ++++++++++
 tb/tb_int32_to_dlfloat16.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/dlfloat16_pkg.sv
// Shared DLfloat16 constants: field widths, bias, exception bit positions and FPU opcodes.
package dlfloat16_pkg;
    localparam int          DLF_EXP_W   = 6;
    localparam int          DLF_MANT_W  = 9;
    localparam int          DLF_BIAS    = 31;
    localparam logic [5:0]  DLF_EXP_INF = 6'h3F;

    localparam int EXC_INVALID   = 4;
    localparam int EXC_DIVZERO   = 3;
    localparam int EXC_OVERFLOW  = 2;
    localparam int EXC_UNDERFLOW = 1;
    localparam int EXC_INEXACT   = 0;

    localparam logic [3:0] ENA_F2I = 4'b1000;
    localparam logic [3:0] ENA_I2F = 4'b1001;
endpackage

// File: rtl/int32_to_dlfloat16_if.sv
// Handshake bus of the int32 -> DLfloat16 converter: operand side and result side.
interface int32_to_dlfloat16_if;
    logic [3:0]  ena;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] float_out;
    logic [4:0]  exceptions;

    modport slave  (input  ena, in_valid, int_in, out_ready,
                    output in_ready, out_valid, float_out, exceptions);
    modport master (output ena, in_valid, int_in, out_ready,
                    input  in_ready, out_valid, float_out, exceptions);
endinterface

// File: rtl/lzc32.sv
// Combinational leading-zero count of a 32-bit word; all-zero input yields 32.
module lzc32 (
    input  logic [31:0] i_data,
    output logic [5:0]  o_lzc
);
    always_comb begin
        o_lzc = 6'd32;
        // Ascending scan: the highest set bit is the last one to write.
        for (int i = 0; i < 32; i++) begin
            if (i_data[i]) o_lzc = 6'(31 - i);
        end
    end
endmodule

// File: rtl/int32_to_dlfloat16.sv
// Three-stage signed int32 -> DLfloat16 converter (RNE) with valid/ready on both sides.
module int32_to_dlfloat16
    import dlfloat16_pkg::*;
#(
    parameter logic [3:0] ENA_CODE = ENA_I2F,
    parameter int         BIAS     = DLF_BIAS
) (
    input  logic                  clk,
    input  logic                  rst,
    int32_to_dlfloat16_if.slave   bus
);
    localparam int STAGES = 3;

    logic [STAGES:1] r_vld_pipe;
    logic [STAGES:1] w_adv;

    // A stage loads when empty or when its current contents move on this cycle.
    assign w_adv[3]     = !r_vld_pipe[3] || bus.out_ready;
    assign w_adv[2]     = !r_vld_pipe[2] || w_adv[3];
    assign w_adv[1]     = !r_vld_pipe[1] || w_adv[2];
    assign bus.in_ready = w_adv[1];

    logic        r_s1_sign, r_s1_en;
    logic [31:0] r_s1_mag;

    logic        r_s2_sign, r_s2_en, r_s2_zero;
    logic [4:0]  r_s2_p;
    logic [30:0] r_s2_norm;

    logic [15:0] r_float;
    logic [4:0]  r_exc;

    logic [5:0]  w_lzc;
    logic [8:0]  w_mant;
    logic        w_guard, w_sticky, w_rnd, w_carry;
    logic [9:0]  w_mant_r;
    logic [5:0]  w_exp;
    logic [15:0] w_float;
    logic [4:0]  w_exc;

    lzc32 u_lzc (.i_data(r_s1_mag), .o_lzc(w_lzc));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_en    <= 1'b0;
            r_s1_mag   <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_en    <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_p     <= '0;
            r_s2_norm  <= '0;
            r_float    <= '0;
            r_exc      <= '0;
        end else begin
            if (w_adv[1]) r_vld_pipe[1] <= bus.in_valid;
            if (w_adv[2]) r_vld_pipe[2] <= r_vld_pipe[1];
            if (w_adv[3]) r_vld_pipe[3] <= r_vld_pipe[2];

            if (w_adv[1] && bus.in_valid) begin
                r_s1_sign <= bus.int_in[31];
                r_s1_mag  <= bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;
                r_s1_en   <= (bus.ena == ENA_CODE);
            end
            if (w_adv[2] && r_vld_pipe[1]) begin
                r_s2_sign <= r_s1_sign;
                r_s2_en   <= r_s1_en;
                r_s2_zero <= (r_s1_mag == 32'd0);
                r_s2_p    <= 5'(6'd31 - w_lzc);
                // Hidden bit lands at bit 31 and is implied, so only 30:0 is kept.
                r_s2_norm <= 31'(r_s1_mag << w_lzc);
            end
            if (w_adv[3] && r_vld_pipe[2]) begin
                r_float <= w_float;
                r_exc   <= w_exc;
            end
        end
    end

    always_comb begin
        w_mant   = r_s2_norm[30:22];
        w_guard  = r_s2_norm[21];
        w_sticky = |r_s2_norm[20:0];
        w_rnd    = w_guard && (w_sticky || w_mant[0]);
        w_mant_r = {1'b0, w_mant} + {9'd0, w_rnd};
        w_carry  = w_mant_r[9];
        // Largest p is 31 only for 2^31, which is exact, so exp tops out at 62.
        w_exp    = 6'(r_s2_p) + 6'(BIAS) + {5'd0, w_carry};
        w_float  = {r_s2_sign, w_exp, w_mant_r[8:0]};
        w_exc    = '0;
        w_exc[EXC_INEXACT] = w_guard || w_sticky;
        if (!r_s2_en || r_s2_zero) begin
            w_float = '0;
            w_exc   = '0;
        end
    end

    assign bus.out_valid  = r_vld_pipe[3];
    assign bus.float_out  = r_float;
    assign bus.exceptions = r_exc;
endmodule

// File: tb/tb_int32_to_dlfloat16.sv
// Scoreboard bench for int32_to_dlfloat16: directed vectors, backpressure and mid-flight reset.
module tb_int32_to_dlfloat16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        logic [15:0] f;
        logic [4:0]  x;
        int          t0;
        bit          lat;
    } exp_t;
    exp_t sb[$];

    int32_to_dlfloat16_if bus();
    int32_to_dlfloat16 dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endfunction

    // Monitor: pop and compare whenever a result is consumed.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {16'd0, bus.float_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("float_out", {16'd0, bus.float_out}, {16'd0, e.f});
                chk("exceptions", {27'd0, bus.exceptions}, {27'd0, e.x});
                if (e.lat) chk("latency", cyc - e.t0, 3);
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] op,
                        input logic [15:0] f, input logic [4:0] x,
                        input bit lat, input bit push);
        int n = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.int_in   = d;
        bus.ena      = op;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
        end else if (push) begin
            e.f = f; e.x = x; e.t0 = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.int_in    = '0;
        bus.ena       = 4'b1001;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_float_out", {16'd0, bus.float_out}, 0);
        chk("rst_exceptions", {27'd0, bus.exceptions}, 0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
        @(posedge clk); #1;

        // Basic values, rounding, extremes, disabled opcode; back to back.
        send(32'd0,          4'b1001, 16'h0000, 5'd0, 1, 1);
        send(32'd1,          4'b1001, 16'h3E00, 5'd0, 1, 1);
        send(32'hFFFF_FFFF,  4'b1001, 16'hBE00, 5'd0, 1, 1);
        send(32'd1023,       4'b1001, 16'h51FF, 5'd0, 1, 1);
        send(32'd1025,       4'b1001, 16'h5200, 5'd1, 1, 1);
        send(32'd1027,       4'b1001, 16'h5202, 5'd1, 1, 1);
        send(32'd2047,       4'b1001, 16'h5400, 5'd1, 1, 1);
        send(32'h7FFF_FFFF,  4'b1001, 16'h7C00, 5'd1, 1, 1);
        send(32'h8000_0000,  4'b1001, 16'hFC00, 5'd0, 1, 1);
        send(-32'sd1023,     4'b1001, 16'hD1FF, 5'd0, 1, 1);
        send(32'd5,          4'b1000, 16'h0000, 5'd0, 1, 1);
        drain();

        // Backpressure: fill all three stages with out_ready low.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'd1, 4'b1001, 16'h3E00, 5'd0, 0, 1);
        send(32'd2, 4'b1001, 16'h4000, 5'd0, 0, 1);
        send(32'd3, 4'b1001, 16'h4100, 5'd0, 0, 1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 0);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 1);
            chk("bp_hold_float", {16'd0, bus.float_out}, 32'h3E00);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(32'd4, 4'b1001, 16'h4200, 5'd0, 0, 1);
        send(32'd5, 4'b1001, 16'h4280, 5'd0, 0, 1);
        send(32'd6, 4'b1001, 16'h4300, 5'd0, 0, 1);
        drain();

        // Reset with beats in flight, plus a beat presented during reset.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'd7, 4'b1001, 16'h0, 5'd0, 0, 0);
        send(32'd8, 4'b1001, 16'h0, 5'd0, 0, 0);
        send(32'd9, 4'b1001, 16'h0, 5'd0, 0, 0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.int_in   = 32'd5;
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("midrst_float_out", {16'd0, bus.float_out}, 0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(32'd1, 4'b1001, 16'h3E00, 5'd0, 1, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
